// File: rtl/jpeg_escape_pkg.sv
// ---------------------------------------------------------------------------
// jpeg_escape_pkg
//
// Shared definitions for the JPEG byte-unstuffing datapath:
//   ESC_BYTE / STUFF_BYTE  - the 0xFF escape byte and the 0x00 stuffing byte
//                            that follows it in an entropy-coded segment.
//   flush_state_t          - states of the end-of-stream flush sequencer.
//   decode_count()         - 2-bit byte count (0 means 4) to a 0..4 count.
//   encode_count()         - 0..4 count back to the 2-bit encoding.
//
// No ports; imported by bit_unstuffer_escape and byte_acc_pack.
// ---------------------------------------------------------------------------
package jpeg_escape_pkg;

    localparam logic [7:0] ESC_BYTE   = 8'hFF;
    localparam logic [7:0] STUFF_BYTE = 8'h00;

    // Flush sequencer: IDLE accepts input; PIPE lets the last word drain
    // through stage 1; RESID asks the packer to emit its residual; OUT
    // waits for that residual word; END drives flush_out.
    typedef enum logic [2:0] {
        FL_IDLE,
        FL_PIPE,
        FL_RESID,
        FL_OUT,
        FL_END
    } flush_state_t;

    // Byte counts travel on 2-bit ports where 0 stands for a full word.
    function automatic logic [2:0] decode_count(input logic [1:0] enc);
        return (enc == 2'd0) ? 3'd4 : {1'b0, enc};
    endfunction

    function automatic logic [1:0] encode_count(input logic [2:0] n);
        return (n == 3'd4) ? 2'd0 : n[1:0];
    endfunction

endpackage

// File: rtl/byte_acc_pack.sv
// ---------------------------------------------------------------------------
// byte_acc_pack
//
// Second pipeline stage of the unstuffer. Takes a registered input word plus
// a per-byte keep mask, compacts the kept bytes behind the 0..3 bytes still
// held from earlier words, and emits the oldest four bytes whenever at least
// four are available. On a flush request the 1..3 held bytes are emitted
// MSB-aligned with zero padding and the accumulator is emptied.
//
// Ports:
//   xclk, rst       clock and synchronous active-high reset
//   in_valid        stage-1 word valid this cycle
//   in_data[31:0]   stage-1 word, byte 3 (MSB) oldest
//   in_keep[3:0]    keep mask, bit 3 belongs to in_data[31:24]
//   in_cnt[2:0]     number of kept bytes (0..4)
//   flush           emit residual bytes now (never coincides with in_valid)
//   in_mark[3:0]    (marker build only) byte is a marker code
//   marker_stb      (marker build only) emitted word carries a marker code
//   marker_code     (marker build only) oldest marker code in that word
//   d_out[31:0]     packed output word, holds when dv is low
//   bytes_out[1:0]  bytes valid in d_out, 0 means 4
//   dv              d_out/bytes_out valid
//
// Optional feature macro: BIT_UNSTUFFER_MARKER_DET_EN adds the marker ports.
// ---------------------------------------------------------------------------
module byte_acc_pack
    import jpeg_escape_pkg::*;
(
    input  logic        xclk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_keep,
    input  logic [2:0]  in_cnt,
    input  logic        flush,
`ifdef BIT_UNSTUFFER_MARKER_DET_EN
    input  logic [3:0]  in_mark,
    output logic        marker_stb,
    output logic [7:0]  marker_code,
`endif
    output logic [31:0] d_out,
    output logic [1:0]  bytes_out,
    output logic        dv
);

    logic [7:0] acc_byte [0:2];
    logic [2:0] acc_cnt;

    logic [7:0] merged [0:6];
    logic [2:0] total;
    logic [2:0] idx;

`ifdef BIT_UNSTUFFER_MARKER_DET_EN
    logic       acc_mk    [0:2];
    logic       merged_mk [0:6];
    logic       word_mk_hit;
    logic [7:0] word_mk_code;
    logic       res_mk_hit;
    logic [7:0] res_mk_code;
`endif

    // Build a byte queue of up to seven entries: first the bytes held over
    // from earlier words, then the kept bytes of the incoming word in stream
    // order. The first four entries form the next output word and the rest
    // become the new residual.
    always_comb begin
        for (int i = 0; i < 7; i++) begin
            merged[i] = 8'h00;
        end
        for (int i = 0; i < 3; i++) begin
            if (3'(i) < acc_cnt) begin
                merged[i] = acc_byte[i];
            end
        end
        idx = acc_cnt;
        if (in_valid) begin
            for (int i = 0; i < 4; i++) begin
                if (in_keep[3-i]) begin
                    merged[idx] = in_data[8*(3-i) +: 8];
                    idx = idx + 3'd1;
                end
            end
        end
        total = acc_cnt + (in_valid ? in_cnt : 3'd0);
    end

`ifdef BIT_UNSTUFFER_MARKER_DET_EN
    // Marker flags ride along with their bytes so the strobe lines up with
    // whichever output word finally carries the marker code, even when that
    // byte sat in the residual for a while. The downward loops leave the
    // oldest marker in the word as the reported one.
    always_comb begin
        for (int i = 0; i < 7; i++) begin
            merged_mk[i] = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            if (3'(i) < acc_cnt) begin
                merged_mk[i] = acc_mk[i];
            end
        end
        if (in_valid) begin
            for (int i = 0; i < 4; i++) begin
                if (in_keep[3-i] && in_mark[3-i]) begin
                    merged_mk[3'(int'(acc_cnt) + $countones(in_keep >> (4 - i)))] = 1'b1;
                end
            end
        end
        word_mk_hit  = 1'b0;
        word_mk_code = 8'h00;
        for (int i = 3; i >= 0; i--) begin
            if (merged_mk[i]) begin
                word_mk_hit  = 1'b1;
                word_mk_code = merged[i];
            end
        end
        res_mk_hit  = 1'b0;
        res_mk_code = 8'h00;
        for (int i = 2; i >= 0; i--) begin
            if ((3'(i) < acc_cnt) && acc_mk[i]) begin
                res_mk_hit  = 1'b1;
                res_mk_code = acc_byte[i];
            end
        end
    end
`endif

    // Output and residual registers. A full word always wins over a flush;
    // the sequencer upstream guarantees the two never land in the same
    // cycle, so the ordering only matters for robustness. d_out and
    // bytes_out are only written when a word goes out, so they hold
    // otherwise.
    always_ff @(posedge xclk) begin
        if (rst) begin
            dv        <= 1'b0;
            d_out     <= 32'h0;
            bytes_out <= 2'd0;
            acc_cnt   <= 3'd0;
            for (int k = 0; k < 3; k++) begin
                acc_byte[k] <= 8'h00;
            end
        end else begin
            dv <= 1'b0;
            if (in_valid && (total >= 3'd4)) begin
                dv        <= 1'b1;
                d_out     <= {merged[0], merged[1], merged[2], merged[3]};
                bytes_out <= encode_count(3'd4);
                acc_cnt   <= total - 3'd4;
                for (int k = 0; k < 3; k++) begin
                    acc_byte[k] <= merged[k+4];
                end
            end else if (flush) begin
                if (acc_cnt != 3'd0) begin
                    dv        <= 1'b1;
                    d_out     <= {acc_byte[0], acc_byte[1], acc_byte[2], 8'h00};
                    bytes_out <= encode_count(acc_cnt);
                end
                acc_cnt <= 3'd0;
            end else if (in_valid) begin
                acc_cnt <= total;
                for (int k = 0; k < 3; k++) begin
                    acc_byte[k] <= merged[k];
                end
            end
        end
    end

`ifdef BIT_UNSTUFFER_MARKER_DET_EN
    // Marker strobe and code follow the same emit decisions as the data
    // word so they are valid in exactly the cycle the code byte appears.
    always_ff @(posedge xclk) begin
        if (rst) begin
            marker_stb  <= 1'b0;
            marker_code <= 8'h00;
            for (int k = 0; k < 3; k++) begin
                acc_mk[k] <= 1'b0;
            end
        end else begin
            marker_stb <= 1'b0;
            if (in_valid && (total >= 3'd4)) begin
                marker_stb <= word_mk_hit;
                if (word_mk_hit) begin
                    marker_code <= word_mk_code;
                end
                for (int k = 0; k < 3; k++) begin
                    acc_mk[k] <= merged_mk[k+4];
                end
            end else if (flush) begin
                marker_stb <= res_mk_hit;
                if (res_mk_hit) begin
                    marker_code <= res_mk_code;
                end
                for (int k = 0; k < 3; k++) begin
                    acc_mk[k] <= 1'b0;
                end
            end else if (in_valid) begin
                for (int k = 0; k < 3; k++) begin
                    acc_mk[k] <= merged_mk[k];
                end
            end
        end
    end
`endif

endmodule

// File: rtl/bit_unstuffer_escape.sv
// ---------------------------------------------------------------------------
// bit_unstuffer_escape
//
// Removes JPEG byte stuffing (the 0x00 that follows every 0xFF in an
// entropy-coded segment) from a stream of MSB-aligned 32-bit words and
// repacks the surviving bytes into full output words. Stage 1 classifies
// each byte against a carried "last kept byte was 0xFF" flag; stage 2
// (byte_acc_pack) compacts and packs. A flush drains the residual bytes and
// pulses flush_out one cycle after the residual word.
//
// Ports:
//   xclk               clock
//   rst                synchronous active-high reset
//   din[31:0]          stuffed data, byte 3 first
//   bytes_in[1:0]      valid bytes in din (MSB aligned), 0 means 4
//   in_stb             din/bytes_in strobe
//   flush_in           end-of-stream pulse
//   d_out[31:0]        unstuffed data, MSB aligned, holds when dv is low
//   bytes_out[1:0]     valid bytes in d_out when dv, 0 means 4
//   dv                 d_out/bytes_out valid
//   flush_out          flush marker, delayed to follow the last data
//   marker_stb         marker code detected (tied low without the macro)
//   marker_code[7:0]   byte that followed 0xFF (tied low without the macro)
//
// Optional feature macro: BIT_UNSTUFFER_MARKER_DET_EN enables detection of
// 0xFF followed by a byte other than 0x00/0xFF.
// ---------------------------------------------------------------------------
module bit_unstuffer_escape
    import jpeg_escape_pkg::*;
(
    input  logic        xclk,
    input  logic        rst,
    input  logic [31:0] din,
    input  logic [1:0]  bytes_in,
    input  logic        in_stb,
    input  logic        flush_in,
    output logic [31:0] d_out,
    output logic [1:0]  bytes_out,
    output logic        dv,
    output logic        flush_out,
    output logic        marker_stb,
    output logic [7:0]  marker_code
);

    flush_state_t fl_state;
    logic         acc_flush;
    logic         accept;
    logic         flush_start;

    logic         carry;
    logic         carry_n;
    logic [2:0]   valid_n;
    logic [7:0]   cur;
    logic [3:0]   keep_n;
    logic [2:0]   cnt_n;

    logic         s1_valid;
    logic [31:0]  s1_data;
    logic [3:0]   s1_keep;
    logic [2:0]   s1_cnt;

`ifdef BIT_UNSTUFFER_MARKER_DET_EN
    logic [3:0]   mark_n;
    logic [3:0]   s1_mark;
`endif

    // While a flush is draining, new words and new flushes are dropped so
    // the residual and flush_out timing cannot be disturbed.
    assign accept      = in_stb   && (fl_state == FL_IDLE);
    assign flush_start = flush_in && (fl_state == FL_IDLE);

    // Walk the valid bytes in stream order. A 0x00 directly after a kept
    // 0xFF is stuffing and is dropped, which also consumes the escape. Any
    // kept 0xFF re-arms the flag, so 0xFF 0xFF 0x00 keeps both 0xFFs. A byte
    // other than 0x00/0xFF right after 0xFF is a marker code and is kept.
    always_comb begin
        carry_n = carry;
        valid_n = decode_count(bytes_in);
        cur     = 8'h00;
        keep_n  = 4'b0000;
        cnt_n   = 3'd0;
`ifdef BIT_UNSTUFFER_MARKER_DET_EN
        mark_n  = 4'b0000;
`endif
        for (int i = 0; i < 4; i++) begin
            cur = din[8*(3-i) +: 8];
            if (3'(i) < valid_n) begin
                if (carry_n && (cur == STUFF_BYTE)) begin
                    carry_n = 1'b0;
                end else begin
                    keep_n[3-i] = 1'b1;
                    cnt_n       = cnt_n + 3'd1;
`ifdef BIT_UNSTUFFER_MARKER_DET_EN
                    if (carry_n && (cur != ESC_BYTE)) begin
                        mark_n[3-i] = 1'b1;
                    end
`endif
                    carry_n = (cur == ESC_BYTE);
                end
            end
        end
    end

    // Stage 1 register: the raw word, its keep mask and kept count. The
    // escape carry is cleared at the end of a flush so a trailing 0xFF
    // (already passed as data) cannot swallow a 0x00 of the next stream.
    always_ff @(posedge xclk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= 32'h0;
            s1_keep  <= 4'b0000;
            s1_cnt   <= 3'd0;
            carry    <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_data <= din;
                s1_keep <= keep_n;
                s1_cnt  <= cnt_n;
                carry   <= carry_n;
            end else if (fl_state == FL_OUT) begin
                carry <= 1'b0;
            end
        end
    end

`ifdef BIT_UNSTUFFER_MARKER_DET_EN
    // Marker flags travel alongside the stage 1 word.
    always_ff @(posedge xclk) begin
        if (rst) begin
            s1_mark <= 4'b0000;
        end else if (accept) begin
            s1_mark <= mark_n;
        end
    end
`endif

    // Flush sequencer. The word strobed together with flush_in still needs
    // one cycle in stage 1 and one in the packer, so the residual request
    // goes out two cycles after the flush, the residual word appears a
    // cycle later, and flush_out follows that by one more cycle.
    always_ff @(posedge xclk) begin
        if (rst) begin
            fl_state  <= FL_IDLE;
            acc_flush <= 1'b0;
            flush_out <= 1'b0;
        end else begin
            acc_flush <= 1'b0;
            flush_out <= 1'b0;
            case (fl_state)
                FL_IDLE: begin
                    if (flush_start) begin
                        fl_state <= FL_PIPE;
                    end
                end
                FL_PIPE: begin
                    fl_state  <= FL_RESID;
                    acc_flush <= 1'b1;
                end
                FL_RESID: begin
                    fl_state <= FL_OUT;
                end
                FL_OUT: begin
                    fl_state  <= FL_END;
                    flush_out <= 1'b1;
                end
                FL_END: begin
                    fl_state <= FL_IDLE;
                end
                default: begin
                    fl_state <= FL_IDLE;
                end
            endcase
        end
    end

    byte_acc_pack u_pack (
        .xclk        (xclk),
        .rst         (rst),
        .in_valid    (s1_valid),
        .in_data     (s1_data),
        .in_keep     (s1_keep),
        .in_cnt      (s1_cnt),
        .flush       (acc_flush),
`ifdef BIT_UNSTUFFER_MARKER_DET_EN
        .in_mark     (s1_mark),
        .marker_stb  (marker_stb),
        .marker_code (marker_code),
`endif
        .d_out       (d_out),
        .bytes_out   (bytes_out),
        .dv          (dv)
    );

`ifndef BIT_UNSTUFFER_MARKER_DET_EN
    assign marker_stb  = 1'b0;
    assign marker_code = 8'h00;
`endif

endmodule
